// File: rtl/des_pkg.sv
// Shared DES key-schedule constants and helpers.
// Holds the width constants, the PC-1/PC-2 selection tables, the encryption
// left-shift schedule and the state type of the decrypt-order scheduler.
// All vectors use DES numbering: vector bit [W] is DES bit 1 (the MSB).
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int HALF_W   = 28;
    localparam int CD_W     = 2 * HALF_W;
    localparam int SUBKEY_W = 48;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_t;

    // PC-1: entry j gives the DES key bit that lands in CD bit j+1.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: entry j gives the CD bit that lands in subkey bit j+1.
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Encryption left-shift per round. The decrypt path undoes round r's
    // shift with a right rotate of the same amount when leaving round r.
    localparam logic [1:0] SHIFT_ENC [1:16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Shift amount for a round number; rounds outside 1..16 map to 1 so the
    // rotator always sees a legal amount (the result is unused there).
    function automatic logic [1:0] shift_enc(input logic [4:0] rnd);
        logic [1:0] amt;
        amt = 2'd1;
        for (int i = 1; i <= 16; i++) begin
            if (rnd == 5'(i)) amt = SHIFT_ENC[i];
        end
        return amt;
    endfunction

    function automatic logic [CD_W:1] pc1(input logic [KEY_W:1] key);
        logic [CD_W:1] cd;
        cd = '0;
        for (int j = 0; j < CD_W; j++) begin
            cd[CD_W - j] = key[KEY_W + 1 - PC1_TAB[j]];
        end
        return cd;
    endfunction

    function automatic logic [SUBKEY_W:1] pc2(input logic [CD_W:1] cd);
        logic [SUBKEY_W:1] sk;
        sk = '0;
        for (int j = 0; j < SUBKEY_W; j++) begin
            sk[SUBKEY_W - j] = cd[CD_W + 1 - PC2_TAB[j]];
        end
        return sk;
    endfunction

endpackage

// File: rtl/des_rotr28.sv
// 28-bit right rotate of one DES key half (DES bit 1 at vector bit [28]).
// Ports:
//   din  - half to rotate
//   amt  - rotate amount, 1 or 2 (any value other than 2 rotates by 1)
//   dout - rotated half
module des_rotr28
    import des_pkg::*;
(
    input  logic [HALF_W:1] din,
    input  logic [1:0]      amt,
    output logic [HALF_W:1] dout
);

    // Right rotate moves the last DES bit back to the front of the half.
    assign dout = (amt == 2'd2) ? {din[2:1], din[HALF_W:3]}
                                : {din[1],   din[HALF_W:2]};

endmodule

// File: rtl/des_keysched_dec.sv
// DES key schedule in decryption order: emits K16 first down to K1, one
// subkey per valid/ready handshake, by right-rotating the C/D halves.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   start         - begin a schedule (taken only when idle); samples key_in
//   key_in        - 64-bit DES key, key_in[64] is DES bit 1
//   subkey        - PC-2 of the current CD, subkey[48] is PC-2 bit 1
//   subkey_round  - round number of subkey, 16 down to 1
//   subkey_valid  - subkey/subkey_round valid
//   subkey_ready  - consumer takes the subkey this cycle
//   busy          - schedule in progress
//   done          - one-cycle pulse after K1 is taken
module des_keysched_dec
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_W:1]      key_in,
    output logic [SUBKEY_W:1]   subkey,
    output logic [4:0]          subkey_round,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic                busy,
    output logic                done
);

    ks_state_t       state, state_d;
    logic [CD_W:1]   cd, cd_d;
    logic [4:0]      round, round_d;
    logic            done_d;
    logic [1:0]      amt;
    logic [HALF_W:1] c_rot, d_rot;

    // C16 == C0 because the encryption shifts total 28, so the PC-1 result
    // is already the K16 state and the first subkey needs no rotation.
    assign amt = shift_enc(round);

    des_rotr28 u_rot_c (
        .din  (cd[CD_W:HALF_W+1]),
        .amt  (amt),
        .dout (c_rot)
    );

    des_rotr28 u_rot_d (
        .din  (cd[HALF_W:1]),
        .amt  (amt),
        .dout (d_rot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cd    <= '0;
            round <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            cd    <= cd_d;
            round <= round_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        cd_d    = cd;
        round_d = round;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cd_d    = pc1(key_in);
                    round_d = 5'd16;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Without ready, CD and round hold so subkey stays stable.
                if (subkey_ready) begin
                    if (round == 5'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        cd_d    = '0;
                        round_d = '0;
                    end else begin
                        cd_d    = {c_rot, d_rot};
                        round_d = round - 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Subkey is combinational from CD: valid in the cycle after start.
    assign subkey       = pc2(cd);
    assign subkey_round = round;
    assign subkey_valid = (state == RUN);
    assign busy         = (state == RUN);

endmodule

// File: tb/tb_des_keysched_dec.sv
module tb_des_keysched_dec;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [64:1] key_in;
    logic [48:1] subkey;
    logic [4:0]  subkey_round;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        busy;
    logic        done;

    des_keysched_dec dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key_in       (key_in),
        .subkey       (subkey),
        .subkey_round (subkey_round),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Encryption schedule K1..K16 for key 133457799BBCDFF1 (textbook values).
    localparam logic [47:0] ENC_K [1:16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };
    localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_PAR = 64'h123456789ABCDEF0;

    typedef struct packed {
        logic [47:0] sk;
        logic [4:0]  rnd;
    } exp_t;

    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          hs_cnt = 0;
    bit          rnd_ready = 1'b0;
    bit          exp_done = 1'b0;
    bit          stalled = 1'b0;
    logic [47:0] held_sk;
    logic [4:0]  held_rnd;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push_seq(input bit zero);
        exp_t e;
        for (int r = 16; r >= 1; r--) begin
            e.sk  = zero ? 48'h0 : ENC_K[r];
            e.rnd = 5'(r);
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start(input logic [63:0] k);
        @(posedge clk); #1;
        key_in = k;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_finish(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending want 0", name, sb.size());
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        check({name, "_done_count"}, 64'(done_cnt), 64'd1);
    endtask

    // Consumer ready: held high, or pseudo-random when rnd_ready is set.
    initial begin
        subkey_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            subkey_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks hold under
    // backpressure and that done follows the K1 handshake by one cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled  = 1'b0;
                exp_done = 1'b0;
            end else begin
                checks++;
                if (done !== exp_done) begin
                    errors++;
                    $display("FAIL done_timing: got %b want %b", done, exp_done);
                end
                if (done) done_cnt++;
                exp_done = 1'b0;
                if (stalled) begin
                    checks++;
                    if (subkey_valid !== 1'b1 || subkey !== held_sk || subkey_round !== held_rnd) begin
                        errors++;
                        $display("FAIL hold: got %b/%h/%0d want 1/%h/%0d",
                                 subkey_valid, subkey, subkey_round, held_sk, held_rnd);
                    end
                end
                stalled = 1'b0;
                if (subkey_valid && subkey_ready) begin
                    hs_cnt++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_subkey: got %h round %0d want none", subkey, subkey_round);
                    end else begin
                        e = sb.pop_front();
                        if (subkey !== e.sk || subkey_round !== e.rnd) begin
                            errors++;
                            $display("FAIL subkey: got %h round %0d want %h round %0d",
                                     subkey, subkey_round, e.sk, e.rnd);
                        end
                        if (e.rnd == 5'd1) exp_done = 1'b1;
                    end
                end else if (subkey_valid) begin
                    stalled  = 1'b1;
                    held_sk  = subkey;
                    held_rnd = subkey_round;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        #12;
        check("rst_busy",   64'(busy),         64'd0);
        check("rst_valid",  64'(subkey_valid), 64'd0);
        check("rst_done",   64'(done),         64'd0);
        check("rst_round",  64'(subkey_round), 64'd0);
        check("rst_subkey", 64'(subkey),       64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Free-running, ready held high; first subkey right after start.
        rnd_ready = 1'b0;
        done_cnt  = 0;
        push_seq(1'b0);
        pulse_start(KEY_A);
        check("first_valid",  64'(subkey_valid), 64'd1);
        check("first_busy",   64'(busy),         64'd1);
        check("first_subkey", 64'(subkey),       64'hCB3D8B0E17F5);
        check("first_round",  64'(subkey_round), 64'd16);
        wait_finish("free");
        check("idle_busy", 64'(busy), 64'd0);

        // Random backpressure.
        rnd_ready = 1'b1;
        done_cnt  = 0;
        push_seq(1'b0);
        pulse_start(KEY_A);
        wait_finish("backpressure");
        rnd_ready = 1'b0;

        // Start pulses with another key while busy are ignored.
        done_cnt = 0;
        push_seq(1'b0);
        pulse_start(KEY_A);
        @(posedge clk);
        pulse_start(64'hFEDCBA9876543210);
        pulse_start(64'h0F1E2D3C4B5A6978);
        check("busy_during_ignored", 64'(busy), 64'd1);
        wait_finish("ignored_start");

        // Parity bits only differ: same schedule.
        done_cnt = 0;
        push_seq(1'b0);
        pulse_start(KEY_PAR);
        wait_finish("parity");

        // Asynchronous reset after round 10 is taken, then an all-zero key.
        done_cnt = 0;
        hs_cnt   = 0;
        push_seq(1'b0);
        pulse_start(KEY_A);
        n = 0;
        while (hs_cnt < 7 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("reach_round10", 64'(hs_cnt), 64'd7);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid",  64'(subkey_valid), 64'd0);
        check("mid_rst_busy",   64'(busy),         64'd0);
        check("mid_rst_done",   64'(done),         64'd0);
        check("mid_rst_round",  64'(subkey_round), 64'd0);
        check("mid_rst_subkey", 64'(subkey),       64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        push_seq(1'b1);
        pulse_start(64'h0);
        check("zero_first_round", 64'(subkey_round), 64'd16);
        wait_finish("zero_key");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
